popcnt_accum: RTL and testbench
===============================

# popcnt_accum

Frame accumulator directly downstream of the 12-input ones-counter (carry-save adder tree). Each cycle it accepts the counter's 4-bit ones-count for one 12-bit input word and sums it over a frame of up to FRAME words. It then presents the frame total, word count, threshold flag and saturation flag on a registered valid/ready output. It is the first sequential stage after the purely combinational counter.

## Interface
- DEPTH, 12: bits per input word; the largest legal in_cnt.
- CW, 4: width of in_cnt; equals $clog2(DEPTH+1).
- FRAME, 16: words per full frame (≥1).
- AW, 8: accumulator/total width.
- WW, 5: word-count width; equals $clog2(FRAME+1).

- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  in_cnt/in_last valid.
- in_ready  out  1  block can accept a word this cycle.
- in_cnt  in  CW  ones-count of one word, {cy, sum[2:0]} from the counter.
- in_last  in  1  closes the frame early with this word.
- thresh  in  AW  compare level, sampled at frame close.
- out_valid  out  1  frame result held.
- out_ready  in  1  consumer takes the result.
- out_total  out  AW  frame sum, saturated.
- out_words  out  WW  words in the frame (1..FRAME).
- out_hit  out  1  out_total >= sampled thresh.
- out_sat  out  1  frame sum exceeded 2^AW-1.
- err_range  out  1  sticky: an in_cnt > DEPTH was accepted.

## Operation
- Accept: a word is accepted when in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational from out_ready, with no combinational path from in_valid.
- State machine, with two states:
  - EMPTY: accumulator acc=0, word counter wc=0.
  - ACC: wc ≥ 1.
- EMPTY → ACC on an accept that does not close the frame.
- ACC → ACC on an accept while wc+1 < FRAME and !in_last.
- Any state → EMPTY on a closing accept:
  - A closing accept is one where in_last=1, or wc+1 == FRAME.
  - On a closing accept, the output register loads, then acc=0 and wc=0.
  - The closing word's count is included in the closed frame.
- FRAME=1: every accept closes the frame.
- Range clamp: in_cnt > DEPTH is treated as DEPTH, and sets err_range. err_range clears only on rst.
- Arithmetic:
  - Next sum = acc + clamped in_cnt, computed at AW+1 bits.
  - If the result exceeds 2^AW-1, acc holds 2^AW-1 and a per-frame sat flag sets.
  - The sat flag clears when the frame closes.
- Output register load, on a closing accept:
  - out_total = saturated next sum.
  - out_words = wc+1.
  - out_hit = (saturated next sum >= thresh), using thresh as sampled that cycle.
  - out_sat = per-frame sat flag OR this word's overflow.
  - out_valid sets.
- Output handshake:
  - out_valid && out_ready with no closing accept in the same cycle: out_valid clears.
  - out_valid && out_ready with a closing accept in the same cycle: the register reloads and out_valid stays 1.
- Output stability: while out_valid && !out_ready, all out_* hold stable and in_ready=0. The accumulator does not advance.

## Timing
- Reset values:
  - Outputs: out_valid=0, out_total=0, out_words=0, out_hit=0, out_sat=0, err_range=0.
  - Internal: acc=0, wc=0, sat flag=0, state EMPTY.
  - in_ready=1 during and after reset.
- rst mid-frame discards the partial frame and any held result immediately (asynchronous). The first accept after rst deassertion starts a new frame.
- Latency: a closing word accepted at edge N gives out_valid=1 and a valid result after edge N, i.e. a 1-cycle latency.
- Throughput: one word per cycle, back-to-back frames at full rate, provided out_ready=1 continuously.
- No input bubbles are required between frames.
- in_last on a word where wc+1 == FRAME: this is a single close, and out_words = FRAME.
- in_valid=0 cycles inside a frame leave acc and wc unchanged.

## Test plan
- Full frame: after reset, 16 accepted words with in_cnt=12, out_ready=1, thresh=150 -> one cycle after the 16th accept: out_valid=1, out_total=192, out_words=16, out_hit=1, out_sat=0.
- Early close: words with counts 3, 5, 7, the last having in_last=1, thresh=20 -> out_total=15, out_words=3, out_hit=0. The next word starts a fresh frame from 0.
- Backpressure: frame closes while out_ready=0 -> out_valid held and in_ready=0 for 5 cycles, out_* stable. Raising out_ready restores in_ready the same cycle. A second frame closing on that handshake cycle keeps out_valid=1 with the new total.
- Saturation: AW=6 build, 16 words of count 12 -> out_total=63, out_sat=1. The next frame of 2×count 1 gives out_total=2, out_sat=0.
- Range error: one word with in_cnt=15 (DEPTH=12) in a 2-word frame with a count-4 word -> out_total=16, err_range=1 and remains 1 until rst.
- Async reset mid-frame: rst pulse after 7 accepted words, mid-cycle -> all outputs 0 immediately. The following 16-word frame of count 1 gives out_total=16, out_words=16.

Source files
------------

// File: rtl/popcnt_accum.sv
// Frame accumulator for the 12-input ones-counter. It sums the per-word ones-counts over a frame
// of up to FRAME words. The frame total, word count, threshold hit and saturation flag are
// presented on a registered valid/ready output.
module popcnt_accum #(
  parameter int unsigned DEPTH = 12,
  parameter int unsigned CW    = 4,
  parameter int unsigned FRAME = 16,
  parameter int unsigned AW    = 8,
  parameter int unsigned WW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_cnt,
  input  logic          in_last,
  input  logic [AW-1:0] thresh,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_total,
  output logic [WW-1:0] out_words,
  output logic          out_hit,
  output logic          out_sat,
  output logic          err_range
);

  localparam int unsigned   SW         = AW + 1;
  localparam logic [CW-1:0] DepthCnt   = CW'(DEPTH);
  localparam logic [WW-1:0] FrameWords = WW'(FRAME);
  localparam logic [AW-1:0] AccMax     = '1;

  typedef enum logic [0:0] {StEmpty, StAcc} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [WW-1:0] wc_q, wc_d;
  logic          sat_q, sat_d;
  logic          err_q, err_d;

  logic          ov_q, ov_d;
  logic [AW-1:0] ot_q, ot_d;
  logic [WW-1:0] ow_q, ow_d;
  logic          oh_q, oh_d;
  logic          os_q, os_d;

  logic          accept, closing, range_bad, ovf;
  logic [CW-1:0] cnt_clamped;
  logic [SW-1:0] sum_wide;
  logic [AW-1:0] sum_sat;
  logic [WW-1:0] wc_inc;

  // Handshake and datapath: clamp, add one bit wider, saturate.
  always_comb begin
    in_ready    = !ov_q || out_ready;
    accept      = in_valid && in_ready;
    range_bad   = in_cnt > DepthCnt;
    cnt_clamped = range_bad ? DepthCnt : in_cnt;
    sum_wide    = {1'b0, acc_q} + SW'(cnt_clamped);
    // acc never exceeds 2^AW-1, so the carry bit alone marks overflow.
    ovf         = sum_wide[AW];
    sum_sat     = ovf ? AccMax : sum_wide[AW-1:0];
    wc_inc      = wc_q + WW'(1);
    closing     = accept && (in_last || (wc_inc == FrameWords));
  end

  // Frame FSM and accumulator next state.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    wc_d    = wc_q;
    sat_d   = sat_q;
    err_d   = err_q | (accept & range_bad);
    if (closing) begin
      state_d = StEmpty;
      acc_d   = '0;
      wc_d    = '0;
      sat_d   = 1'b0;
    end else if (accept) begin
      unique case (state_q)
        StEmpty: state_d = StAcc;
        StAcc:   state_d = StAcc;
        default: state_d = StEmpty;
      endcase
      acc_d = sum_sat;
      wc_d  = wc_inc;
      sat_d = sat_q | ovf;
    end
  end

  // Output register: reload on close, otherwise drop valid once it is taken.
  always_comb begin
    ov_d = ov_q;
    ot_d = ot_q;
    ow_d = ow_q;
    oh_d = oh_q;
    os_d = os_q;
    if (closing) begin
      ov_d = 1'b1;
      ot_d = sum_sat;
      ow_d = wc_inc;
      oh_d = sum_sat >= thresh;
      os_d = sat_q | ovf;
    end else if (ov_q && out_ready) begin
      ov_d = 1'b0;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      acc_q   <= '0;
      wc_q    <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
      ot_q    <= '0;
      ow_q    <= '0;
      oh_q    <= 1'b0;
      os_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      wc_q    <= wc_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
      ov_q    <= ov_d;
      ot_q    <= ot_d;
      ow_q    <= ow_d;
      oh_q    <= oh_d;
      os_q    <= os_d;
    end
  end

  assign out_valid = ov_q;
  assign out_total = ot_q;
  assign out_words = ow_q;
  assign out_hit   = oh_q;
  assign out_sat   = os_q;
  assign err_range = err_q;

endmodule

// File: tb/tb_popcnt_accum.sv
// Directed bench for popcnt_accum: default build plus an AW=6 build for saturation.
module tb_popcnt_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_ready, in_last, out_valid, out_ready, out_hit, out_sat, err_range;
  logic [3:0] in_cnt;
  logic [7:0] thresh, out_total;
  logic [4:0] out_words;

  logic       s_in_valid, s_in_ready, s_in_last, s_out_valid, s_out_ready, s_out_hit, s_out_sat;
  logic       s_err_range;
  logic [3:0] s_in_cnt;
  logic [5:0] s_thresh, s_out_total;
  logic [4:0] s_out_words;

  int total = 0;
  int bad   = 0;

  popcnt_accum dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_cnt(in_cnt),
    .in_last(in_last), .thresh(thresh), .out_valid(out_valid), .out_ready(out_ready),
    .out_total(out_total), .out_words(out_words), .out_hit(out_hit), .out_sat(out_sat),
    .err_range(err_range)
  );

  popcnt_accum #(.AW(6)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_cnt(s_in_cnt),
    .in_last(s_in_last), .thresh(s_thresh), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_total(s_out_total), .out_words(s_out_words), .out_hit(s_out_hit), .out_sat(s_out_sat),
    .err_range(s_err_range)
  );

  task automatic send(input logic [3:0] c, input logic l);
    in_valid = 1'b1; in_cnt = c; in_last = l;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_s(input logic [3:0] c, input logic l);
    s_in_valid = 1'b1; s_in_cnt = c; s_in_last = l;
    @(posedge clk); #1;
    s_in_valid = 1'b0; s_in_last = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if ({out_total, out_words, out_hit, out_sat, err_range} !== 16'h0) begin
      bad++; $display("FAIL rst_outputs got=%h want=0", {out_total, out_words, out_hit, out_sat, err_range});
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL post_rst got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_full_frame();
    thresh = 8'd150; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(4'd12, 1'b0);
      if (i < 15) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_early_valid word=%0d got=%b want=0", i, out_valid); end
      end
    end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL full_valid got=%b want=1", out_valid); end
    total++; if (out_total !== 8'd192) begin bad++; $display("FAIL full_total got=%0d want=192", out_total); end
    total++; if (out_words !== 5'd16) begin bad++; $display("FAIL full_words got=%0d want=16", out_words); end
    total++; if (out_hit !== 1'b1) begin bad++; $display("FAIL full_hit got=%b want=1", out_hit); end
    total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL full_sat got=%b want=0", out_sat); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_early_close();
    thresh = 8'd20;
    send(4'd3, 1'b0); send(4'd5, 1'b0); send(4'd7, 1'b1);
    total++; if (out_total !== 8'd15) begin bad++; $display("FAIL early_total got=%0d want=15", out_total); end
    total++; if (out_words !== 5'd3) begin bad++; $display("FAIL early_words got=%0d want=3", out_words); end
    total++; if (out_hit !== 1'b0) begin bad++; $display("FAIL early_hit got=%b want=0", out_hit); end
    send(4'd2, 1'b1);
    total++; if (out_valid !== 1'b1 || out_total !== 8'd2 || out_words !== 5'd1) begin
      bad++; $display("FAIL fresh_frame got v=%b t=%0d w=%0d want 1/2/1", out_valid, out_total, out_words);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    thresh = 8'd5; out_ready = 1'b0;
    send(4'd1, 1'b0); send(4'd1, 1'b0); send(4'd1, 1'b0); send(4'd1, 1'b1);
    total++; if (out_valid !== 1'b1 || out_total !== 8'd4 || out_hit !== 1'b0) begin
      bad++; $display("FAIL bp_first got v=%b t=%0d h=%b want 1/4/0", out_valid, out_total, out_hit);
    end
    in_valid = 1'b1; in_cnt = 4'd9; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_total !== 8'd4 || out_words !== 5'd4) begin
        bad++; $display("FAIL bp_hold cyc=%0d got v=%b r=%b t=%0d w=%0d want 1/0/4/4", i, out_valid, in_ready, out_total, out_words);
      end
    end
    out_ready = 1'b1; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_comb got=%b want=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    total++; if (out_valid !== 1'b1 || out_total !== 8'd9 || out_words !== 5'd1 || out_hit !== 1'b1) begin
      bad++; $display("FAIL bp_reload got v=%b t=%0d w=%0d h=%b want 1/9/1/1", out_valid, out_total, out_words, out_hit);
    end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_saturation();
    s_thresh = 6'd63; s_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send_s(4'd12, 1'b0);
    total++; if (s_out_valid !== 1'b1 || s_out_total !== 6'd63 || s_out_words !== 5'd16) begin
      bad++; $display("FAIL sat_frame got v=%b t=%0d w=%0d want 1/63/16", s_out_valid, s_out_total, s_out_words);
    end
    total++; if (s_out_sat !== 1'b1 || s_out_hit !== 1'b1) begin
      bad++; $display("FAIL sat_flag got sat=%b hit=%b want 1/1", s_out_sat, s_out_hit);
    end
    send_s(4'd1, 1'b0); send_s(4'd1, 1'b1);
    total++; if (s_out_total !== 6'd2 || s_out_sat !== 1'b0 || s_out_words !== 5'd2) begin
      bad++; $display("FAIL sat_clear got t=%0d sat=%b w=%0d want 2/0/2", s_out_total, s_out_sat, s_out_words);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_range();
    thresh = 8'd16;
    total++; if (err_range !== 1'b0) begin bad++; $display("FAIL range_init got=%b want=0", err_range); end
    send(4'd15, 1'b0);
    total++; if (err_range !== 1'b1) begin bad++; $display("FAIL range_set got=%b want=1", err_range); end
    send(4'd4, 1'b1);
    total++; if (out_total !== 8'd16 || out_words !== 5'd2 || out_hit !== 1'b1) begin
      bad++; $display("FAIL range_total got t=%0d w=%0d h=%b want 16/2/1", out_total, out_words, out_hit);
    end
    send(4'd1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    total++; if (err_range !== 1'b1) begin bad++; $display("FAIL range_sticky got=%b want=1", err_range); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) send(4'd1, 1'b0);
    #3 rst = 1'b1;
    #1;
    total++; if ({out_valid, out_total, out_words, out_hit, out_sat, err_range} !== 17'h0) begin
      bad++; $display("FAIL arst_outputs got=%h want=0", {out_valid, out_total, out_words, out_hit, out_sat, err_range});
    end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%b want=1", in_ready); end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      send(4'd1, (i == 15));
      if (i < 15) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_early_valid word=%0d got=%b want=0", i, out_valid); end
      end
    end
    total++; if (out_valid !== 1'b1 || out_total !== 8'd16 || out_words !== 5'd16) begin
      bad++; $display("FAIL arst_frame got v=%b t=%0d w=%0d want 1/16/16", out_valid, out_total, out_words);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_cnt = '0; in_last = 1'b0; thresh = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_cnt = '0; s_in_last = 1'b0; s_thresh = '0; s_out_ready = 1'b1;
    test_reset();
    test_full_frame();
    test_early_close();
    test_backpressure();
    test_saturation();
    test_range();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
